// File: rtl/alu_flags_pipe.sv
// ALU flag unit: computes AC/LC/Z/S/V, holds them in a maskable register,
// offers a small LIFO save/restore stack and a carry-select delay line.
module alu_flags_pipe #(
  parameter int WIDTH       = 8,
  parameter int SEL_BITS    = 2,
  parameter int SEL_DELAY   = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ArithCarryIn,
  input  logic                               LogicCarryIn,
  input  logic [WIDTH-1:0]                   DataIn,
  input  logic [WIDTH-1:0]                   LHSIn,
  input  logic [WIDTH-1:0]                   RHSIn,
  input  logic                               SubOp,
  input  logic                               FlagsWe,
  input  logic [4:0]                         FlagMask,
  input  logic                               ZeroChain,
  input  logic                               Push,
  input  logic                               Pop,
  input  logic [SEL_BITS-1:0]                CarrySelIn,
  output logic [SEL_BITS-1:0]                CarrySelOut,
  output logic                               ArithCarryFlag,
  output logic                               LogicCarryFlag,
  output logic                               ZeroFlag,
  output logic                               SignFlag,
  output logic                               OverflowFlag,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   StackCount,
  output logic                               StackErr
);

  localparam int CNT_W = $clog2(STACK_DEPTH+1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // flag register bit positions, packed as {V,S,Z,LC,AC}
  localparam int F_AC = 0;
  localparam int F_LC = 1;
  localparam int F_Z  = 2;
  localparam int F_S  = 3;
  localparam int F_V  = 4;

  logic [4:0]       flags_q, flags_d;
  logic [CNT_W-1:0] sp_q, sp_d;
  logic             err_q, err_d;
  logic [4:0]       mem_q [STACK_DEPTH];
  logic             wr_en;

  logic [4:0]       fl_new;
  logic             z_new, v_new, rhs_eff;
  logic             push_op, pop_op, full, empty;
  logic [CNT_W-1:0] sp_m1;

  always_comb begin
    rhs_eff = RHSIn[WIDTH-1] ^ SubOp;
    z_new   = (DataIn == '0) & (~ZeroChain | flags_q[F_Z]);
    v_new   = (LHSIn[WIDTH-1] == rhs_eff) & (DataIn[WIDTH-1] != LHSIn[WIDTH-1]);
    fl_new  = '0;
    fl_new[F_AC] = ArithCarryIn;
    fl_new[F_LC] = LogicCarryIn;
    fl_new[F_Z]  = z_new;
    fl_new[F_S]  = DataIn[WIDTH-1];
    fl_new[F_V]  = v_new;
  end

  assign push_op = Push & ~Pop;
  assign pop_op  = Pop & ~Push;
  assign full    = (sp_q == CNT_W'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign sp_m1   = sp_q - 1'b1;

  // Pop overrides a same-cycle flag write; Push saves the pre-update value.
  always_comb begin
    flags_d = flags_q;
    sp_d    = sp_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (pop_op) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        flags_d = mem_q[sp_m1[PTR_W-1:0]];
        sp_d    = sp_m1;
      end
    end else begin
      if (push_op) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + 1'b1;
        end
      end
      if (FlagsWe)
        flags_d = (fl_new & FlagMask) | (flags_q & ~FlagMask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[sp_q[PTR_W-1:0]] <= flags_q;
  end

  assign ArithCarryFlag = flags_q[F_AC];
  assign LogicCarryFlag = flags_q[F_LC];
  assign ZeroFlag       = flags_q[F_Z];
  assign SignFlag       = flags_q[F_S];
  assign OverflowFlag   = flags_q[F_V];
  assign StackCount     = sp_q;
  assign StackErr       = err_q;

  generate
    if (SEL_DELAY == 0) begin : g_sel_wire
      assign CarrySelOut = CarrySelIn;
    end else begin : g_sel_dly
      logic [SEL_DELAY-1:0][SEL_BITS-1:0] sel_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sel_q <= '0;
        end else begin
          sel_q[0] <= CarrySelIn;
          for (int i = 1; i < SEL_DELAY; i++)
            sel_q[i] <= sel_q[i-1];
        end
      end
      assign CarrySelOut = sel_q[SEL_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_alu_flags_pipe.sv
// Bench for alu_flags_pipe: directed spec scenarios plus random traffic
// checked against a queue-based reference model.
module tb_alu_flags_pipe;
  localparam int W    = 8;
  localparam int SB   = 2;
  localparam int SD   = 2;
  localparam int SDEP = 4;
  localparam int CW   = $clog2(SDEP+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ArithCarryIn, LogicCarryIn, SubOp, FlagsWe, ZeroChain, Push, Pop;
  logic [W-1:0]  DataIn, LHSIn, RHSIn;
  logic [4:0]    FlagMask;
  logic [SB-1:0] CarrySelIn, CarrySelOut;
  logic          ArithCarryFlag, LogicCarryFlag, ZeroFlag, SignFlag, OverflowFlag;
  logic [CW-1:0] StackCount;
  logic          StackErr;

  alu_flags_pipe #(.WIDTH(W), .SEL_BITS(SB), .SEL_DELAY(SD), .STACK_DEPTH(SDEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ArithCarryIn(ArithCarryIn), .LogicCarryIn(LogicCarryIn),
    .DataIn(DataIn), .LHSIn(LHSIn), .RHSIn(RHSIn), .SubOp(SubOp),
    .FlagsWe(FlagsWe), .FlagMask(FlagMask), .ZeroChain(ZeroChain),
    .Push(Push), .Pop(Pop),
    .CarrySelIn(CarrySelIn), .CarrySelOut(CarrySelOut),
    .ArithCarryFlag(ArithCarryFlag), .LogicCarryFlag(LogicCarryFlag),
    .ZeroFlag(ZeroFlag), .SignFlag(SignFlag), .OverflowFlag(OverflowFlag),
    .StackCount(StackCount), .StackErr(StackErr)
  );

  always #5 clk = ~clk;

  wire [4:0] flags = {OverflowFlag, SignFlag, ZeroFlag, LogicCarryFlag, ArithCarryFlag};

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // reference model state
  logic [4:0]    mf;
  logic          merr;
  logic [4:0]    mstk[$];
  logic [SB-1:0] selq[$];
  logic [SB-1:0] msel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ArithCarryIn = 0; LogicCarryIn = 0; SubOp = 0; FlagsWe = 0; ZeroChain = 0;
    Push = 0; Pop = 0; DataIn = '0; LHSIn = '0; RHSIn = '0; FlagMask = '0;
    CarrySelIn = '0;
  endtask

  task automatic model_reset();
    mf = '0;
    merr = 1'b0;
    mstk.delete();
    selq.delete();
    repeat (SD-1) selq.push_back('0);
    msel = '0;
  endtask

  task automatic model_step();
    logic [4:0] nv;
    logic lneg, rneg, dneg;
    lneg = (int'(LHSIn) >= (1 << (W-1)));
    rneg = (int'(RHSIn) >= (1 << (W-1))) != SubOp;
    dneg = (int'(DataIn) >= (1 << (W-1)));
    nv[0] = ArithCarryIn;
    nv[1] = LogicCarryIn;
    nv[2] = (DataIn == 0) && (!ZeroChain || mf[2]);
    nv[3] = dneg;
    nv[4] = (lneg == rneg) && (dneg != lneg);
    merr = 1'b0;
    if (Pop && !Push) begin
      if (mstk.size() == 0) merr = 1'b1;
      else mf = mstk.pop_back();
    end else begin
      if (Push && !Pop) begin
        if (mstk.size() == SDEP) merr = 1'b1;
        else mstk.push_back(mf);
      end
      if (FlagsWe)
        for (int b = 0; b < 5; b++)
          if (FlagMask[b]) mf[b] = nv[b];
    end
    selq.push_back(CarrySelIn);
    msel = selq.pop_front();
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("flags", 32'(flags), 32'(mf));
    chk("count", 32'(StackCount), 32'(mstk.size()));
    chk("err", 32'(StackErr), 32'(merr));
    chk("sel", 32'(CarrySelOut), 32'(msel));
  endtask

  logic [4:0] saved;

  initial begin
    idle();
    model_reset();
    #2;
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_count", 32'(StackCount), 32'h0);
    chk("rst_err", 32'(StackErr), 32'h0);
    chk("rst_sel", 32'(CarrySelOut), 32'h0);
    #10 rst_n = 1'b1;

    // 0x7F + 0x01 signed overflow
    LHSIn = 8'h7F; RHSIn = 8'h01; DataIn = 8'h80; ArithCarryIn = 1;
    FlagsWe = 1; FlagMask = 5'h1F;
    cyc();
    chk("add_V", 32'(OverflowFlag), 32'h1);
    chk("add_S", 32'(SignFlag), 32'h1);
    chk("add_Z", 32'(ZeroFlag), 32'h0);
    chk("add_AC", 32'(ArithCarryFlag), 32'h1);

    // 16-bit zero chaining
    idle(); FlagsWe = 1; FlagMask = 5'h1F;
    DataIn = 8'h00; ZeroChain = 0; cyc();
    DataIn = 8'h00; ZeroChain = 1; cyc();
    chk("zchain_00_00", 32'(ZeroFlag), 32'h1);
    DataIn = 8'h00; ZeroChain = 0; cyc();
    DataIn = 8'h05; ZeroChain = 1; cyc();
    chk("zchain_00_05", 32'(ZeroFlag), 32'h0);

    // build flags = 1F, then masked write clears only Z
    idle(); FlagsWe = 1; FlagMask = 5'b11011;
    LHSIn = 8'h7F; RHSIn = 8'h01; DataIn = 8'h80; ArithCarryIn = 1; LogicCarryIn = 1;
    cyc();
    idle(); FlagsWe = 1; FlagMask = 5'b00100; DataIn = 8'h00; cyc();
    chk("mask_pre", 32'(flags), 32'h1F);
    idle(); FlagsWe = 1; FlagMask = 5'b00100; DataIn = 8'h01; cyc();
    chk("mask_post", 32'(flags), 32'h1B);

    // fill the stack with four values distinguished by AC/LC
    for (int i = 0; i < 4; i++) begin
      idle(); FlagsWe = 1; FlagMask = 5'b00011;
      ArithCarryIn = i[0]; LogicCarryIn = i[1];
      cyc();
      idle(); Push = 1; cyc();
    end
    chk("push4_count", 32'(StackCount), 32'd4);
    idle(); Push = 1; cyc();
    chk("push_full_err", 32'(StackErr), 32'h1);
    chk("push_full_count", 32'(StackCount), 32'd4);
    idle(); cyc();
    chk("err_one_cycle", 32'(StackErr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(); Pop = 1; cyc();
      chk("pop_lifo", 32'(flags[1:0]), 32'(3 - i));
      chk("pop_count", 32'(StackCount), 32'(3 - i));
    end
    idle(); Pop = 1; cyc();
    chk("pop_empty_err", 32'(StackErr), 32'h1);
    chk("pop_empty_count", 32'(StackCount), 32'd0);

    // push+pop together, then pop beats a flag write
    saved = mf;
    idle(); Push = 1; cyc();
    idle(); Push = 1; Pop = 1; cyc();
    chk("pushpop_count", 32'(StackCount), 32'd1);
    chk("pushpop_flags", 32'(flags), 32'(saved));
    chk("pushpop_err", 32'(StackErr), 32'h0);
    idle(); FlagsWe = 1; FlagMask = 5'h1F; DataIn = 8'h00; ArithCarryIn = ~saved[0];
    LogicCarryIn = ~saved[1]; cyc();
    idle(); Pop = 1; FlagsWe = 1; FlagMask = 5'h1F; DataIn = 8'h80;
    ArithCarryIn = ~saved[0]; cyc();
    chk("pop_wins", 32'(flags), 32'(saved));

    // carry-select delay of two cycles
    idle(); cyc(); cyc();
    CarrySelIn = 2'b10; cyc();
    chk("sel_d1", 32'(CarrySelOut), 32'h0);
    CarrySelIn = 2'b00; cyc();
    chk("sel_d2", 32'(CarrySelOut), 32'h2);
    cyc();
    chk("sel_d3", 32'(CarrySelOut), 32'h0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      ArithCarryIn = 1'($urandom);
      LogicCarryIn = 1'($urandom);
      SubOp        = 1'($urandom);
      FlagsWe      = ($urandom_range(0, 2) != 0);
      FlagMask     = 5'($urandom);
      ZeroChain    = 1'($urandom);
      Push         = ($urandom_range(0, 3) == 0);
      Pop          = ($urandom_range(0, 3) == 0);
      DataIn       = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      LHSIn        = W'($urandom);
      RHSIn        = W'($urandom);
      CarrySelIn   = SB'($urandom);
      cyc();
    end

    // asynchronous reset in the middle of traffic
    idle(); CarrySelIn = 2'b11; FlagsWe = 1; FlagMask = 5'h1F; ArithCarryIn = 1; DataIn = 8'h00;
    cyc();
    idle(); CarrySelIn = 2'b11; Push = 1; cyc();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_flags", 32'(flags), 32'h0);
    chk("midrst_count", 32'(StackCount), 32'h0);
    chk("midrst_err", 32'(StackErr), 32'h0);
    chk("midrst_sel", 32'(CarrySelOut), 32'h0);
    #2 rst_n = 1'b1;
    idle();
    for (int n = 0; n < 8; n++) begin
      Push = (n < 3);
      CarrySelIn = SB'(n);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
